multicycle_control: RTL and testbench

- Main control FSM of the multi-cycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the register file write enable (reg_we), memory strobes, and the PC/IR latches.
- Sits directly upstream of the register file, whose writes it schedules in the WB states.

---
 rtl/multicycle_control.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core. Steps each instruction through fetch, decode,
// execute, memory and writeback, and drives the datapath strobes and mux selects.
module multicycle_control #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       oldpc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       iord,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       pc_src,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StExecI   = 4'd3,
        StMemAddr = 4'd4,
        StMemRd   = 4'd5,
        StMemWr   = 4'd6,
        StWbAlu   = 4'd7,
        StWbMem   = 4'd8,
        StBranch  = 4'd9,
        StJal     = 4'd10,
        StTrap    = 4'd11
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [3:0] AluAdd = 4'd0;
    localparam logic [3:0] AluSub = 4'd1;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [7:0] cnt_q, cnt_d;
    logic       waiting;
    logic       taken;

    // SUB only exists for register-register ops; funct7_5 selects SRA for both forms.
    function automatic logic [3:0] exec_op(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && f7) ? AluSub : AluAdd;
            3'b111:  op = 4'd2;
            3'b110:  op = 4'd3;
            3'b100:  op = 4'd4;
            3'b010:  op = 4'd5;
            3'b001:  op = 4'd6;
            3'b101:  op = f7 ? 4'd8 : 4'd7;
            default: op = AluAdd;
        endcase
        return op;
    endfunction

    assign taken = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero);

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        cnt_d     = '0;
        waiting   = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
                else           waiting = 1'b1;
            end
            StDecode: begin
                state_d = StTrap;
                case (opcode)
                    OpR:      state_d = StExecR;
                    OpI:      state_d = StExecI;
                    OpLoad:   if (funct3 == 3'b010) state_d = StMemAddr;
                    OpStore:  if (funct3 == 3'b010) state_d = StMemAddr;
                    OpBranch: if (funct3 == 3'b000 || funct3 == 3'b001) state_d = StBranch;
                    OpJal:    state_d = StJal;
                    default:  state_d = StTrap;
                endcase
            end
            StExecR, StExecI: state_d = StWbAlu;
            StMemAddr: state_d = (opcode == OpLoad) ? StMemRd : StMemWr;
            StMemRd: begin
                if (mem_ready) state_d = StWbMem;
                else           waiting = 1'b1;
            end
            StMemWr: begin
                if (mem_ready) state_d = StFetch;
                else           waiting = 1'b1;
            end
            StWbAlu, StWbMem, StBranch, StJal: state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StTrap;
        endcase
        // mem_ready always wins: the counter only advances on cycles without it.
        if (waiting) begin
            cnt_d = cnt_q + 8'd1;
            if ((MEM_TIMEOUT != 8'd0) && (cnt_d == MEM_TIMEOUT)) state_d = StTrap;
        end
        if (state_d == StTrap) illegal_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        pc_we     = 1'b0;
        oldpc_we  = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        alu_op    = AluAdd;
        pc_src    = 1'b0;
        wb_sel    = 2'd0;
        unique case (state_q)
            StFetch: begin
                mem_re    = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_we    = 1'b1;
                    oldpc_we = 1'b1;
                    pc_we    = 1'b1;
                end
            end
            StDecode: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
            end
            StExecR: begin
                alu_src_a = 2'd2;
                alu_op    = exec_op(funct3, funct7_5, 1'b1);
            end
            StExecI: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                alu_op    = exec_op(funct3, funct7_5, 1'b0);
            end
            StMemAddr: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
            end
            StMemRd: begin
                mem_re = 1'b1;
                iord   = 1'b1;
            end
            StMemWr: begin
                mem_we = 1'b1;
                iord   = 1'b1;
            end
            StWbAlu: reg_we = 1'b1;
            StWbMem: begin
                reg_we = 1'b1;
                wb_sel = 2'd1;
            end
            StBranch: begin
                alu_src_a = 2'd2;
                alu_op    = AluSub;
                if (taken) begin
                    pc_we  = 1'b1;
                    pc_src = 1'b1;
                end
            end
            StJal: begin
                reg_we = 1'b1;
                wb_sel = 2'd2;
                pc_we  = 1'b1;
                pc_src = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            pc_we    = 1'b0;
            oldpc_we = 1'b0;
            ir_we    = 1'b0;
            reg_we   = 1'b0;
            mem_re   = 1'b0;
            mem_we   = 1'b0;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: builds per-instruction expected cycle traces from the ISA
// sequencing rules, then replays randomized instructions and memory latencies against the DUT.
module tb_multicycle_control;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int KR = 0, KI = 1, KLW = 2, KSW = 3, KBEQ = 4, KBNE = 5, KJAL = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic funct7_5 = 1'b0, alu_zero = 1'b0, mem_ready = 1'b0;
    logic pc_we, oldpc_we, ir_we, reg_we, mem_re, mem_we, iord, pc_src, illegal;
    logic [1:0] alu_src_a, alu_src_b, wb_sel;
    logic [3:0] alu_op, state;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(8'd4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_we(pc_we), .oldpc_we(oldpc_we),
        .ir_we(ir_we), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .iord(iord),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .wb_sel(wb_sel), .illegal(illegal), .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic pc_we, oldpc_we, ir_we, reg_we, mem_re, mem_we, iord;
        logic [1:0] sa, sb;
        logic [3:0] op;
        logic pcs;
        logic [1:0] wb;
    } exp_t;

    typedef struct {
        logic rst;
        logic [6:0] opc;
        logic [2:0] f3;
        logic f7;
        logic mr;
        logic az;
        exp_t e;
        int ill;
        string tag;
    } cyc_t;

    cyc_t q[$];
    logic [6:0] cur_opc;
    logic [2:0] cur_f3;
    logic cur_f7;
    int n_tests = 0;
    int n_fail = 0;
    int alu_tab [8] = '{0, 6, 5, 0, 4, 7, 3, 2};
    int f3_pool [7] = '{0, 1, 2, 4, 5, 6, 7};
    logic [6:0] valid_ops [6] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic f7, input logic is_r);
        if (f3 == 3'd0 && is_r && f7) return 4'd1;
        if (f3 == 3'd5 && f7) return 4'd8;
        return 4'(alu_tab[f3]);
    endfunction

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        cur_opc = opc;
        cur_f3  = f3;
        cur_f7  = f7;
    endtask

    task automatic push(input exp_t e, input logic mr, input logic az, input int ill,
                        input string tag);
        cyc_t c;
        c.rst = 1'b0; c.opc = cur_opc; c.f3 = cur_f3; c.f7 = cur_f7;
        c.mr = mr; c.az = az; c.e = e; c.ill = ill; c.tag = tag;
        q.push_back(c);
    endtask

    task automatic push_fetch_wait();
        exp_t e;
        e = blank(4'd0); e.mem_re = 1'b1; e.sb = 2'd1;
        push(e, 1'b0, rnd(), 0, "fetch_wait");
    endtask

    task automatic add_fetch(input int waits);
        exp_t e;
        for (int i = 0; i < waits; i++) push_fetch_wait();
        e = blank(4'd0); e.mem_re = 1'b1; e.sb = 2'd1;
        e.ir_we = 1'b1; e.oldpc_we = 1'b1; e.pc_we = 1'b1;
        push(e, 1'b1, rnd(), 0, "fetch_done");
        e = blank(4'd1); e.sa = 2'd1; e.sb = 2'd2;
        push(e, rnd(), rnd(), 0, "decode");
    endtask

    task automatic add_trap(input int n);
        for (int i = 0; i < n; i++) begin
            set_instr(valid_ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), rnd());
            push(blank(4'd11), rnd(), rnd(), (i == 0) ? -1 : 1, "trap");
        end
    endtask

    task automatic add_reset(input exp_t e);
        push(e, rnd(), rnd(), -1, "reset_cycle");
        q[q.size() - 1].rst = 1'b1;
    endtask

    task automatic add_instr(input int kind, input logic [2:0] f3, input logic f7, input int fw,
                             input int mw, input logic az);
        exp_t e;
        case (kind)
            KR:      set_instr(OP_R, f3, f7);
            KI:      set_instr(OP_I, f3, f7);
            KLW:     set_instr(OP_LD, 3'd2, f7);
            KSW:     set_instr(OP_ST, 3'd2, f7);
            KBEQ:    set_instr(OP_BR, 3'd0, f7);
            KBNE:    set_instr(OP_BR, 3'd1, f7);
            default: set_instr(OP_JAL, f3, f7);
        endcase
        add_fetch(fw);
        case (kind)
            KR, KI: begin
                e = blank((kind == KR) ? 4'd2 : 4'd3);
                e.sa = 2'd2; e.sb = (kind == KR) ? 2'd0 : 2'd2;
                e.op = exp_alu(cur_f3, cur_f7, kind == KR);
                push(e, rnd(), rnd(), 0, "exec");
                e = blank(4'd7); e.reg_we = 1'b1;
                push(e, rnd(), rnd(), 0, "wb_alu");
            end
            KLW, KSW: begin
                e = blank(4'd4); e.sa = 2'd2; e.sb = 2'd2;
                push(e, rnd(), rnd(), 0, "mem_addr");
                e = blank((kind == KLW) ? 4'd5 : 4'd6); e.iord = 1'b1;
                if (kind == KLW) e.mem_re = 1'b1;
                else             e.mem_we = 1'b1;
                for (int i = 0; i < mw; i++) push(e, 1'b0, rnd(), 0, "mem_wait");
                push(e, 1'b1, rnd(), 0, "mem_done");
                if (kind == KLW) begin
                    e = blank(4'd8); e.reg_we = 1'b1; e.wb = 2'd1;
                    push(e, rnd(), rnd(), 0, "wb_mem");
                end
            end
            KBEQ, KBNE: begin
                e = blank(4'd9); e.sa = 2'd2; e.op = 4'd1;
                if ((kind == KBEQ) ? az : !az) begin
                    e.pc_we = 1'b1; e.pcs = 1'b1;
                end
                push(e, rnd(), az, 0, "branch");
            end
            default: begin
                e = blank(4'd10); e.reg_we = 1'b1; e.wb = 2'd2; e.pc_we = 1'b1; e.pcs = 1'b1;
                push(e, rnd(), rnd(), 0, "jal");
            end
        endcase
    endtask

    initial begin
        exp_t e;
        exp_t g;
        // Directed cases first.
        add_instr(KR, 3'd0, 1'b1, 0, 0, 1'b0);
        add_instr(KLW, 3'd2, 1'b0, 0, 3, 1'b0);
        add_instr(KBEQ, 3'd0, 1'b0, 0, 0, 1'b1);
        add_instr(KBNE, 3'd1, 1'b0, 0, 0, 1'b1);
        add_instr(KJAL, 3'd0, 1'b0, 0, 0, 1'b0);
        add_instr(KSW, 3'd2, 1'b0, 3, 3, 1'b0);
        add_instr(KI, 3'd5, 1'b1, 2, 0, 1'b0);
        for (int n = 0; n < 40; n++) begin
            add_instr($urandom_range(0, 6), 3'(f3_pool[$urandom_range(0, 6)]), rnd(),
                      $urandom_range(0, 3), $urandom_range(0, 3), rnd());
        end
        // Illegal opcode, then valid opcodes are ignored until reset.
        set_instr(7'b0000000, 3'd0, 1'b0);
        add_fetch(1);
        add_trap(4);
        add_reset(blank(4'd11));
        // Load with a non-word funct3 is also illegal.
        set_instr(OP_LD, 3'd0, 1'b0);
        add_fetch(0);
        add_trap(3);
        add_reset(blank(4'd11));
        add_instr(KR, 3'd7, 1'b0, 0, 0, 1'b0);
        // Fetch timeout after four ready-less cycles.
        set_instr(OP_R, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) push_fetch_wait();
        add_trap(3);
        add_reset(blank(4'd11));
        // Load data timeout.
        set_instr(OP_LD, 3'd2, 1'b0);
        add_fetch(0);
        e = blank(4'd4); e.sa = 2'd2; e.sb = 2'd2;
        push(e, rnd(), rnd(), 0, "mem_addr");
        e = blank(4'd5); e.iord = 1'b1; e.mem_re = 1'b1;
        for (int i = 0; i < 4; i++) push(e, 1'b0, rnd(), 0, "mem_wait_to");
        add_trap(2);
        add_reset(blank(4'd11));
        // Reset while a store waits: the strobe drops that cycle.
        set_instr(OP_ST, 3'd2, 1'b0);
        add_fetch(0);
        e = blank(4'd4); e.sa = 2'd2; e.sb = 2'd2;
        push(e, rnd(), rnd(), 0, "mem_addr");
        e = blank(4'd6); e.iord = 1'b1; e.mem_we = 1'b1;
        push(e, 1'b0, rnd(), 0, "mem_wait");
        e.mem_we = 1'b0;
        add_reset(e);
        add_instr(KJAL, 3'd0, 1'b0, 0, 0, 1'b0);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        foreach (q[i]) begin
            rst_n     = !q[i].rst;
            opcode    = q[i].opc;
            funct3    = q[i].f3;
            funct7_5  = q[i].f7;
            mem_ready = q[i].mr;
            alu_zero  = q[i].az;
            @(negedge clk);
            g.st = state; g.pc_we = pc_we; g.oldpc_we = oldpc_we; g.ir_we = ir_we;
            g.reg_we = reg_we; g.mem_re = mem_re; g.mem_we = mem_we; g.iord = iord;
            g.sa = alu_src_a; g.sb = alu_src_b; g.op = alu_op; g.pcs = pc_src; g.wb = wb_sel;
            check($sformatf("%s#%0d", q[i].tag, i), {10'd0, g}, {10'd0, q[i].e});
            if (q[i].ill >= 0) begin
                check($sformatf("%s_illegal#%0d", q[i].tag, i), {31'd0, illegal},
                      32'(q[i].ill));
            end
            @(posedge clk);
            #1;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
